uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single `uart_tx` serializer among `num_req_p` byte-stream requesters in the UART subsystem, sitting between requesters and `uart_tx`'s `tx_v_i`/`tx_i`/`tx_done_o` ports. Grants are round-robin and message-granular: a winner keeps the transmitter until its byte flagged `last` completes, or until `max_burst_p` bytes are sent. Each byte issue is paced by `uart_tx`'s completion pulse, so `uart_tx` never sees a new byte while busy.

## Interface
- `num_req_p`, 4, number of requesters (≥2)
- `data_bits_p`, 8, byte width; must match `uart_tx`
- `max_burst_p`, 16, max bytes per grant before forced release (≥1)
- `clk_i`  in  1  system clock
- `reset_i`  in  1  synchronous, active-high reset
- `req_v_i`  in  `num_req_p`  per-requester byte valid
- `req_data_i`  in  `num_req_p*data_bits_p`  per-requester byte; requester i occupies bits `[i*data_bits_p +: data_bits_p]`
- `req_last_i`  in  `num_req_p`  byte is last of message
- `req_yumi_o`  out  `num_req_p`  one-hot byte-consumed pulse
- `tx_v_o`  out  1  to `uart_tx.tx_v_i`; one-cycle start pulse
- `tx_data_o`  out  `data_bits_p`  to `uart_tx.tx_i`
- `tx_done_i`  in  1  from `uart_tx.tx_done_o`; one-cycle pulse at end of the final stop bit
- `grant_o`  out  `num_req_p`  one-hot current owner; 0 when idle
- `busy_o`  out  1  a grant is held

## Operation
- States: IDLE, SEND, WAIT.
- IDLE:
  - If any `req_v_i` is set, pick the first set bit at or after `rr_ptr`, with wrap-around.
  - Register the pick in `grant_o`, clear `burst_cnt`, go to SEND.
- SEND, owner g:
  - If `req_v_i[g]`: assert `tx_v_o`, drive `tx_data_o` from g's byte, and assert `req_yumi_o[g]`, all in the same cycle.
  - Latch `last_r` ← `req_last_i[g]`, increment `burst_cnt`, go to WAIT.
  - If `req_v_i[g]`=0: stay in SEND with the grant held. Requesters must not stall mid-message indefinitely.
- WAIT: hold until `tx_done_i`.
  - If `last_r`, or `burst_cnt` = `max_burst_p`: release. Clear `grant_o`, set `rr_ptr` ← (g+1) mod `num_req_p`, go to IDLE.
  - Otherwise go to SEND.
- `tx_done_i` in IDLE or SEND is ignored.
- `tx_data_o` is 0 whenever `tx_v_o`=0.
- `burst_cnt` width is `$clog2(max_burst_p+1)`.
- A released requester that still has `req_v_i` set competes normally in the next IDLE cycle. It is lowest priority because `rr_ptr` has advanced past it.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `grant_o`=0, `busy_o`=0, `tx_v_o`=0, `req_yumi_o`=0, `tx_data_o`=0.
- Reset mid-operation aborts the message. `uart_tx` shares `reset_i`, so no partial state survives.
- Arbitration latency: `req_v_i` sampled high in IDLE at cycle n → `grant_o`/`busy_o` at n+1 and `tx_v_o` at n+1 (SEND), provided `req_v_i[g]` is still high.
- Inter-byte gap: `tx_done_i` at cycle k → next `tx_v_o` at k+1 (WAIT→SEND), or new arbitration in IDLE at k+1 and `tx_v_o` at k+2.
- At most one `req_yumi_o` bit is set per cycle, and only coincident with `tx_v_o`.
- `busy_o` = state ≠ IDLE.
- Simultaneous requests in IDLE: lowest index at or after `rr_ptr` wins.

## Structure
- Package `uart_pkg` holds:
  - the state enum type `uart_tx_arb_state_e` (IDLE/SEND/WAIT);
  - shared defaults `uart_data_bits_gp`=8 and `uart_clk_per_bit_gp`=10416.
- Sub-module `uart_rr_pick`: combinational one-hot round-robin picker.
  - Parameter: `width_p`.
  - Inputs: `req_i`, `ptr_i` (binary).
  - Outputs: `grant_o` one-hot, `v_o`.
  - Implemented by doubling the request vector and masking.
- The top instantiates `uart_rr_pick` once, plus the FSM, `rr_ptr`, `burst_cnt` and `last_r` registers, and the output mux.

## Test plan
- Single requester (`num_req_p`=4): req 2 sends 0x41, 0x42 (last), with `tx_done_i` modelled 5 cycles after each `tx_v_o`. Required: `tx_v_o` at n+1 with 0x41, next `tx_v_o` at done+1 with 0x42, release, `rr_ptr`=3.
- Contention: requesters 0, 1 and 3 hold 1-byte messages simultaneously from reset. Required: grant order 0, 1, 3, then 0 again if re-requested; `req_yumi_o` one-hot and coincident with `tx_v_o`.
- Burst limit (`max_burst_p`=2): req 0 sends a 5-byte message while req 1 waits. Required: order 0,0,1,0,0,0 with no byte lost or duplicated; req 1's `tx_v_o` comes 2 cycles after the second done.
- Mid-message stall: owner drops `req_v_i` for 10 cycles in SEND while other requesters are active. Required: grant held, no `tx_v_o`, resume with correct byte.
- Reset mid-WAIT: assert `reset_i` during WAIT. Required: next cycle all outputs 0, state IDLE, `rr_ptr`=0; a stray `tx_done_i` afterwards is ignored.
- Integration: instantiate with real `uart_tx` (`clk_per_bit_p`=4). Two requesters send "AB" and "C". Required: a serial-line monitor decodes 'A','B','C' in order with no overlapping frames.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART subsystem types and defaults
package uart_pkg;

    localparam int uart_data_bits_gp   = 8;
    localparam int uart_clk_per_bit_gp = 10416;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } uart_tx_arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational one-hot round-robin picker
module uart_rr_pick #(
    parameter int width_p = 4
) (
    input  logic [width_p-1:0]         req_i,
    input  logic [$clog2(width_p)-1:0] ptr_i,
    output logic [width_p-1:0]         grant_o,
    output logic                       v_o
);

    localparam int dbl_lp = 2 * width_p;

    logic [dbl_lp-1:0] dbl_req;
    logic [dbl_lp-1:0] ptr_mask;
    logic [dbl_lp-1:0] masked;
    logic [dbl_lp-1:0] lowest;

    // The upper copy always keeps every request, so wrap-around is covered
    // by the lowest set bit of the masked double vector.
    assign dbl_req  = {req_i, req_i};
    assign ptr_mask = {dbl_lp{1'b1}} << ptr_i;
    assign masked   = dbl_req & ptr_mask;
    assign lowest   = masked & (~masked + dbl_lp'(1));
    assign grant_o  = lowest[width_p-1:0] | lowest[dbl_lp-1:width_p];
    assign v_o      = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular round-robin arbiter in front of uart_tx
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int num_req_p   = 4,
    parameter int data_bits_p = uart_data_bits_gp,
    parameter int max_burst_p = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_req_p-1:0]             req_v_i,
    input  logic [num_req_p*data_bits_p-1:0] req_data_i,
    input  logic [num_req_p-1:0]             req_last_i,
    output logic [num_req_p-1:0]             req_yumi_o,
    output logic                             tx_v_o,
    output logic [data_bits_p-1:0]           tx_data_o,
    input  logic                             tx_done_i,
    output logic [num_req_p-1:0]             grant_o,
    output logic                             busy_o
);

    localparam int ptr_w_lp = $clog2(num_req_p);
    localparam int cnt_w_lp = $clog2(max_burst_p + 1);
    localparam logic [cnt_w_lp-1:0] burst_max_lp = cnt_w_lp'(max_burst_p);
    localparam logic [ptr_w_lp-1:0] ptr_last_lp  = ptr_w_lp'(num_req_p - 1);

    uart_tx_arb_state_e  state_r;
    logic [ptr_w_lp-1:0] rr_ptr_r;
    logic [ptr_w_lp-1:0] owner_r;
    logic [ptr_w_lp-1:0] pick_idx;
    logic [cnt_w_lp-1:0] burst_cnt_r;
    logic                last_r;
    logic [num_req_p-1:0] pick_grant;
    logic                pick_v;
    logic                send_fire;

    uart_rr_pick #(
        .width_p (num_req_p)
    ) picker (
        .req_i   (req_v_i),
        .ptr_i   (rr_ptr_r),
        .grant_o (pick_grant),
        .v_o     (pick_v)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (pick_grant[i]) pick_idx = ptr_w_lp'(i);
        end
    end

    // Byte issue is a same-cycle handshake with the owner's valid.
    assign send_fire  = (state_r == SEND) && req_v_i[owner_r];
    assign tx_v_o     = send_fire;
    assign tx_data_o  = send_fire ? req_data_i[owner_r*data_bits_p +: data_bits_p] : '0;
    assign req_yumi_o = send_fire ? grant_o : '0;
    assign busy_o     = (state_r != IDLE);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= IDLE;
            rr_ptr_r    <= '0;
            owner_r     <= '0;
            burst_cnt_r <= '0;
            last_r      <= 1'b0;
            grant_o     <= '0;
        end else begin
            unique case (state_r)
                IDLE: begin
                    if (pick_v) begin
                        grant_o     <= pick_grant;
                        owner_r     <= pick_idx;
                        burst_cnt_r <= '0;
                        state_r     <= SEND;
                    end
                end
                SEND: begin
                    if (send_fire) begin
                        last_r      <= req_last_i[owner_r];
                        burst_cnt_r <= burst_cnt_r + 1'b1;
                        state_r     <= WAIT;
                    end
                end
                WAIT: begin
                    if (tx_done_i) begin
                        if (last_r || (burst_cnt_r == burst_max_lp)) begin
                            grant_o  <= '0;
                            rr_ptr_r <= (owner_r == ptr_last_lp) ? '0 : owner_r + 1'b1;
                            state_r  <= IDLE;
                        end else begin
                            state_r  <= SEND;
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int DB   = 8;
    localparam int MAXB = 2;

    logic          clk        = 1'b0;
    logic          reset_i    = 1'b1;
    logic [N-1:0]  req_v_i    = '0;
    logic [N-1:0]  req_last_i = '0;
    logic [N*DB-1:0] req_data_i = '0;
    logic          tx_done_i  = 1'b0;
    logic [N-1:0]  req_yumi_o;
    logic [N-1:0]  grant_o;
    logic          tx_v_o;
    logic          busy_o;
    logic [DB-1:0] tx_data_o;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .num_req_p   (N),
        .data_bits_p (DB),
        .max_burst_p (MAXB)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .req_v_i    (req_v_i),
        .req_data_i (req_data_i),
        .req_last_i (req_last_i),
        .req_yumi_o (req_yumi_o),
        .tx_v_o     (tx_v_o),
        .tx_data_o  (tx_data_o),
        .tx_done_i  (tx_done_i),
        .grant_o    (grant_o),
        .busy_o     (busy_o)
    );

    typedef struct packed {
        logic [DB-1:0] data;
        logic          last;
    } beat_t;

    beat_t req_q [N][$];
    int    stall [N];

    int total = 0;
    int bad   = 0;

    int m_owner = -1;
    int m_sent  = 0;
    int m_ptr   = 0;
    bit m_wait  = 1'b0;
    bit m_last  = 1'b0;

    int uart_cnt   = 0;
    int done_delay = 5;
    bit rand_delay = 1'b0;
    bit stray_en   = 1'b0;
    bit force_done = 1'b0;
    int order_code = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_msg(input int r, input int len, input logic [DB-1:0] base);
        beat_t t;
        for (int b = 0; b < len; b++) begin
            t.data = base + DB'(b);
            t.last = (b == len - 1);
            req_q[r].push_back(t);
        end
    endtask

    task automatic cycle(input bit rst);
        bit            exp_v;
        bit            found;
        logic [N-1:0]  exp_grant;
        logic [N-1:0]  exp_yumi;
        logic [DB-1:0] exp_data;
        int            j;
        @(negedge clk);
        reset_i   = rst;
        tx_done_i = 1'b0;
        if (rst) begin
            uart_cnt = 0;
        end else if (uart_cnt > 0) begin
            uart_cnt--;
            tx_done_i = (uart_cnt == 0);
        end else if (force_done || (stray_en && $urandom_range(7) == 0)) begin
            tx_done_i = 1'b1;
        end
        force_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_v_i[i]             = (req_q[i].size() > 0) && (stall[i] == 0);
            req_data_i[i*DB +: DB] = (req_q[i].size() > 0) ? req_q[i][0].data : '0;
            req_last_i[i]          = (req_q[i].size() > 0) ? req_q[i][0].last : 1'b0;
            if (stall[i] > 0) stall[i]--;
        end
        #1;
        if (!rst) begin
            exp_v     = 1'b0;
            exp_grant = '0;
            exp_yumi  = '0;
            exp_data  = '0;
            if (m_owner >= 0) begin
                exp_grant[m_owner] = 1'b1;
                if (!m_wait) exp_v = req_v_i[m_owner];
            end
            if (exp_v) begin
                exp_data          = req_q[m_owner][0].data;
                exp_yumi[m_owner] = 1'b1;
            end
            check("grant",   32'(grant_o),    32'(exp_grant));
            check("busy",    32'(busy_o),     32'(m_owner >= 0));
            check("tx_v",    32'(tx_v_o),     32'(exp_v));
            check("tx_data", 32'(tx_data_o),  32'(exp_data));
            check("yumi",    32'(req_yumi_o), 32'(exp_yumi));
            if (tx_v_o) check("overlap", 32'(uart_cnt), 32'd0);
        end
        if (tx_v_o && !rst) begin
            for (int i = 0; i < N; i++) if (grant_o[i]) order_code = order_code * 8 + i + 1;
            uart_cnt = rand_delay ? int'($urandom_range(1, 6)) : done_delay;
        end
        for (int i = 0; i < N; i++) begin
            if (req_yumi_o[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
        end
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_sent  = 0;
            m_wait  = 1'b0;
            m_last  = 1'b0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (!found && req_v_i[j]) begin
                    found   = 1'b1;
                    m_owner = j;
                    m_sent  = 0;
                end
            end
        end else if (!m_wait) begin
            if (req_v_i[m_owner]) begin
                m_sent++;
                m_last = req_last_i[m_owner];
                m_wait = 1'b1;
            end
        end else if (tx_done_i) begin
            m_wait = 1'b0;
            if (m_last || m_sent == MAXB) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    function automatic bit pending();
        bit p;
        p = (m_owner >= 0);
        for (int i = 0; i < N; i++) if (req_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (pending() && n < 3000) begin
            cycle(1'b0);
            n++;
        end
        if (n >= 3000) check({tag, "_timeout"}, 32'(n), 32'd0);
        cycle(1'b0);
    endtask

    initial begin
        int n;
        int n_tx;
        for (int i = 0; i < N; i++) stall[i] = 0;

        cycle(1'b1);
        cycle(1'b1);
        repeat (3) cycle(1'b0);
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_busy",  32'(busy_o),  32'd0);
        check("rst_tx_v",  32'(tx_v_o),  32'd0);

        order_code = 0;
        push_msg(2, 2, 8'h41);
        drain("single");
        check("single_order", 32'(order_code), 32'o33);
        order_code = 0;
        push_msg(0, 1, 8'h50);
        push_msg(3, 1, 8'h60);
        drain("ptr3");
        check("ptr3_order", 32'(order_code), 32'o41);

        cycle(1'b1);
        order_code = 0;
        push_msg(0, 1, 8'h01);
        push_msg(1, 1, 8'h11);
        push_msg(3, 1, 8'h31);
        drain("contend");
        check("contend_order", 32'(order_code), 32'o124);
        order_code = 0;
        push_msg(0, 1, 8'h02);
        push_msg(1, 1, 8'h12);
        drain("rerequest");
        check("rerequest_order", 32'(order_code), 32'o12);

        cycle(1'b1);
        order_code = 0;
        push_msg(0, 5, 8'h80);
        push_msg(1, 1, 8'h90);
        drain("burst");
        check("burst_order", 32'(order_code), 32'o112111);

        order_code = 0;
        push_msg(2, 2, 8'hA0);
        push_msg(0, 1, 8'hB0);
        n = 0;
        while (!m_wait && n < 200) begin
            cycle(1'b0);
            n++;
        end
        check("rstw_reach_wait", 32'(m_wait), 32'd1);
        cycle(1'b1);
        force_done = 1'b1;
        cycle(1'b0);
        check("rstw_grant", 32'(grant_o),    32'd0);
        check("rstw_busy",  32'(busy_o),     32'd0);
        check("rstw_tx_v",  32'(tx_v_o),     32'd0);
        check("rstw_yumi",  32'(req_yumi_o), 32'd0);
        check("rstw_data",  32'(tx_data_o),  32'd0);
        drain("rstw");
        check("rstw_order", 32'(order_code), 32'o313);

        cycle(1'b1);
        order_code = 0;
        push_msg(0, 2, 8'hC0);
        push_msg(1, 1, 8'hD0);
        push_msg(2, 1, 8'hE0);
        n = 0;
        while (order_code == 0 && n < 200) begin
            cycle(1'b0);
            n++;
        end
        stall[0] = 10;
        n_tx = 0;
        repeat (8) begin
            cycle(1'b0);
            if (tx_v_o) n_tx++;
        end
        check("stall_no_tx", 32'(n_tx),    32'd0);
        check("stall_grant", 32'(grant_o), 32'd1);
        drain("stall");
        check("stall_order", 32'(order_code), 32'o1123);

        cycle(1'b1);
        rand_delay = 1'b1;
        stray_en   = 1'b1;
        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(3) == 0) begin
                n = int'($urandom_range(N - 1));
                if (req_q[n].size() < 6) push_msg(n, int'($urandom_range(1, 4)), 8'($urandom));
            end
            if ($urandom_range(15) == 0) stall[$urandom_range(N - 1)] = int'($urandom_range(1, 6));
            cycle(1'b0);
        end
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
